// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy, threshold and sticky error flags.
// Supports a registered-read mode and a first-word-fall-through mode.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             pop_acc;
    logic             push_acc;
    logic             ovf_q;
    logic             unf_q;

    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // Flags depend only on the registered count.
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_ff @(posedge clk) begin
        if (push_acc && !flush)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_err) | (push & ~push_acc & ~flush);
            unf_q <= (unf_q & ~clr_err) | (pop & ~pop_acc & ~flush);
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] rd_q;
            logic             rv_q;
            // Nonblocking read returns the pre-write head on push+pop at full.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                    rv_q <= 1'b0;
                end else if (flush) begin
                    rv_q <= 1'b0;
                end else begin
                    rv_q <= pop_acc;
                    if (pop_acc)
                        rd_q <= mem[rd_ptr];
                end
            end
            assign rd_data  = rd_q;
            assign rd_valid = rv_q;
        end else begin : g_fwft
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = ~empty;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: standard instance plus an FWFT instance.
// A queue model tracks contents, flags and expected read data.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    logic       f_push = 1'b0, f_pop = 1'b0;
    logic [7:0] f_wr = '0;
    logic [7:0] f_rd;
    logic       f_rv;
    logic [4:0] f_count;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] rdq[$];
    logic [7:0] last_rd = '0;
    logic       exp_rv = 1'b0;
    logic       m_ovf = 1'b0, m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush), .clr_err(clr_err),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .push(f_push), .wr_data(f_wr), .pop(f_pop),
        .rd_data(f_rd), .rd_valid(f_rv), .flush(1'b0), .clr_err(1'b0),
        .count(f_count), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(exp_rv));
        if (rd_valid) begin
            if (rdq.size() == 0) chk({tag, ".rd_sb"}, rdq.size(), 1);
            else chk({tag, ".rd_data"}, int'(rd_data), int'(rdq.pop_front()));
        end
        chk({tag, ".rd_hold"}, int'(rd_data), int'(last_rd));
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".full"}, int'(full), int'(n == 16));
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".af"}, int'(almost_full), int'(n >= 14));
        chk({tag, ".ae"}, int'(almost_empty), int'(n <= 2));
        chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
        chk({tag, ".unf"}, int'(underflow), int'(m_unf));
    endtask

    task automatic cyc(input string tag, input logic p, input logic po,
                       input logic [7:0] d, input logic fl, input logic ce);
        logic pa, wa;
        int n;
        n  = q.size();
        pa = po && (n > 0);
        wa = p && ((n < 16) || pa);
        push = p; pop = po; wr_data = d; flush = fl; clr_err = ce;
        @(posedge clk);
        if (fl) begin
            q.delete();
            exp_rv = 1'b0;
        end else begin
            if (pa) begin
                last_rd = q.pop_front();
                rdq.push_back(last_rd);
            end
            if (wa) q.push_back(d);
            exp_rv = pa;
        end
        m_ovf = (m_ovf && !ce) || (!fl && p && !wa);
        m_unf = (m_unf && !ce) || (!fl && po && !pa);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        rdq.delete();
        last_rd = '0;
        exp_rv = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic ftick(input logic p, input logic po, input logic [7:0] d);
        f_push = p; f_pop = po; f_wr = d;
        @(posedge clk);
        #1;
        f_push = 1'b0; f_pop = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst.f_empty", int'(f_empty), 1);
        chk("rst.f_rd", int'(f_rd), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cyc("t1.push", 1, 0, 8'h11, 0, 0);
        cyc("t1.push", 1, 0, 8'h22, 0, 0);
        cyc("t1.push", 1, 0, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t1.pop", 0, 1, 8'h00, 0, 0);
        cyc("t1.idle", 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 16; i++) cyc("t2.fill", 1, 0, 8'(i), 0, 0);
        cyc("t2.ovf", 1, 0, 8'hEE, 0, 0);
        cyc("t2.clr", 0, 0, 8'h00, 0, 1);

        cyc("t3.pp_full", 1, 1, 8'hAA, 0, 0);
        chk("t3.popped0", int'(rd_data), 8'h00);
        for (int i = 0; i < 16; i++) cyc("t3.drain", 0, 1, 8'h00, 0, 0);
        chk("t3.last_aa", int'(rd_data), 8'hAA);

        cyc("t4.unf", 0, 1, 8'h00, 0, 0);
        cyc("t4.pp_empty", 1, 1, 8'h44, 0, 0);
        cyc("t4.pop", 0, 1, 8'h00, 0, 0);

        for (int i = 0; i < 5; i++) cyc("t6.load", 1, 0, 8'(8'h50 + i), 0, 0);
        cyc("t6.flush", 1, 1, 8'h99, 1, 0);
        cyc("t6.after", 0, 0, 8'h00, 0, 0);
        cyc("t6.clr_set", 0, 1, 8'h00, 0, 1);

        cyc("t6.burst", 1, 0, 8'h61, 0, 0);
        cyc("t6.burst", 1, 0, 8'h62, 0, 0);
        cyc("t6.burst", 1, 1, 8'h63, 0, 0);
        push = 1'b1; wr_data = 8'h64;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.rst");
        push = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("t6.post", 1, 0, 8'h71, 0, 0);
        cyc("t6.post", 0, 1, 8'h00, 0, 0);

        ftick(1, 0, 8'h5C);
        chk("t5.f_rv", int'(f_rv), 1);
        chk("t5.f_rd", int'(f_rd), 8'h5C);
        ftick(0, 0, 8'h00);
        chk("t5.f_hold", int'(f_rd), 8'h5C);
        ftick(1, 0, 8'h66);
        ftick(0, 1, 8'h00);
        chk("t5.f_next", int'(f_rd), 8'h66);
        chk("t5.f_cnt", int'(f_count), 1);
        ftick(0, 1, 8'h00);
        chk("t5.f_empty", int'(f_empty), 1);
        chk("t5.f_rv0", int'(f_rv), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO. It is the next-generation replacement for the fixed-width, fixed-depth test FIFO on the board demo. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and a first-word-fall-through (FWFT) mode. It also adds sticky overflow and underflow error flags with a clear input, and a synchronous flush. It sits behind the button-pulse conditioning logic and drives the LED status bank.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset, asynchronous, active-high.
push  in  1  write request.
wr_data  in  WIDTH  write data, sampled on an accepted push.
pop  in  1  read request.
rd_data  out  WIDTH  read data.
rd_valid  out  1  rd_data qualifier.
flush  in  1  synchronous clear of contents.
clr_err  in  1  clears sticky error flags.
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
overflow  out  1  sticky: a push was rejected.
underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - pointers, count and rd_data = 0.
  - rd_valid = 0, full = 0, empty = 1.
  - almost_full = 0; almost_empty = 1.
  - overflow = 0, underflow = 0.
  - Storage contents are don't-care.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the registered count, not by pointer comparison.
- Accept rules, evaluated on pre-edge state:
  - pop_acc = pop & ~empty.
  - push_acc = push & (~full | pop_acc). A push into a full FIFO is accepted when a pop is accepted in the same cycle.
  - Push+pop on an empty FIFO: push accepted, pop rejected.
- Count: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither occur. All flags derive from the registered count and update on the same edge as count. There is no combinational path from push/pop to any flag.
- Standard mode (FWFT=0):
  - An accepted pop loads mem[rd_ptr] into rd_data at that edge; rd_valid = 1 for exactly that following cycle, otherwise 0.
  - rd_data holds its last value when no pop is accepted.
  - Latency from push to readable is 1 cycle (empty deasserts the cycle after push_acc).
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] and rd_valid = ~empty. The head word is visible without a pop, the cycle after the push that made the FIFO non-empty.
  - pop acknowledges and consumes the head; the next word appears the following cycle.
- Errors:
  - overflow sets on push & ~push_acc.
  - underflow sets on pop & ~pop_acc.
  - Both stay set until clr_err. If clr_err and a new error occur in the same cycle, set wins.
- Flush:
  - Highest priority after rst. Pointers and count go to 0; push and pop that cycle are ignored and do not set error flags.
  - rd_valid is forced to 0 that cycle. rd_data holds in standard mode; error flags are unaffected.
- Simultaneous push+pop at full (standard mode): the read uses the old head and the write goes to wr_ptr, which equals rd_ptr. The old head must be read before it is overwritten, so the memory read must return pre-write data.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33, pop x3 (FWFT=0) -> rd_data 0x11, 0x22, 0x33 with rd_valid one cycle after each pop; count 3->0; empty=1 at end.
2. Push 16 words 0x00..0x0F -> almost_full rises when count=14, full=1 at count=16. A 17th push -> rejected, overflow=1, count=16. Then clr_err -> overflow=0.
3. At full, push 0xAA + pop in the same cycle -> count stays 16, popped word 0x00. After draining 16 pops, the last word out is 0xAA. The read pointer wraps 15->0 with no data loss.
4. Pop while empty -> underflow=1, rd_valid=0, count=0. Push+pop together while empty -> count=1, underflow=1.
5. FWFT=1: push 0x5C -> next cycle rd_valid=1, rd_data=0x5C with no pop issued. Pop -> empty=1, rd_valid=0 the following cycle.
6. Load 5 words, assert flush with push=1 and pop=1 -> count=0, empty=1, almost_empty=1, overflow/underflow unchanged. Assert rst mid-burst -> all outputs return to reset values immediately.
